// File: rtl/iterative_alu_if.sv
// rtl/iterative_alu_if.sv - request/response bundle between the datapath controller and iterative_alu
// The controller drives start/op/operands; the ALU returns busy/done and the registered results.
interface iterative_alu_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] alu_in_1;
  logic [XLEN-1:0] alu_in_2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] alu_result;
  logic            alu_bcond;
  logic            alu_illegal;

  modport master (
    output start, alu_op, alu_in_1, alu_in_2,
    input  busy, done, alu_result, alu_bcond, alu_illegal
  );

  modport slave (
    input  start, alu_op, alu_in_1, alu_in_2,
    output busy, done, alu_result, alu_bcond, alu_illegal
  );
endinterface

// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - execute-stage ALU with single-cycle logic/arith/compare and bit-serial shifts
// Results are registered and announced with a one-cycle done pulse; busy covers the shift cycles.
module iterative_alu #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  iterative_alu_if.slave alu
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] INS_ADD   = 5'd0;
  localparam logic [4:0] INS_ADDI  = 5'd1;
  localparam logic [4:0] INS_SUB   = 5'd2;
  localparam logic [4:0] INS_AND   = 5'd3;
  localparam logic [4:0] INS_ANDI  = 5'd4;
  localparam logic [4:0] INS_OR    = 5'd5;
  localparam logic [4:0] INS_ORI   = 5'd6;
  localparam logic [4:0] INS_XOR   = 5'd7;
  localparam logic [4:0] INS_XORI  = 5'd8;
  localparam logic [4:0] INS_SLL   = 5'd9;
  localparam logic [4:0] INS_SLLI  = 5'd10;
  localparam logic [4:0] INS_SRL   = 5'd11;
  localparam logic [4:0] INS_SRLI  = 5'd12;
  localparam logic [4:0] INS_LW    = 5'd13;
  localparam logic [4:0] INS_SW    = 5'd14;
  localparam logic [4:0] INS_JAL   = 5'd15;
  localparam logic [4:0] INS_JALR  = 5'd16;
  localparam logic [4:0] INS_BEQ   = 5'd17;
  localparam logic [4:0] INS_BNE   = 5'd18;
  localparam logic [4:0] INS_BLT   = 5'd19;
  localparam logic [4:0] INS_BGE   = 5'd20;
  localparam logic [4:0] INS_ECALL = 5'd21;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            right_q, right_d;
  logic            bcond_q, bcond_d;
  logic            illegal_q, illegal_d;
  logic            done_q, done_d;

  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] sc_result;
  logic [XLEN-1:0] acc_shift;
  logic [SHW-1:0]  amt;
  logic            sc_bcond;
  logic            sc_illegal;
  logic            is_shift;
  logic            is_right;

  // Operation decode for the accept edge; shifts report in_1 so k=0 falls out as a single-cycle op.
  always_comb begin
    diff       = alu.alu_in_1 - alu.alu_in_2;
    amt        = alu.alu_in_2[SHW-1:0];
    sc_result  = '0;
    sc_bcond   = 1'b0;
    sc_illegal = 1'b0;
    is_shift   = 1'b0;
    is_right   = 1'b0;
    case (alu.alu_op)
      INS_ADD, INS_ADDI, INS_LW, INS_SW, INS_JAL, INS_JALR:
        sc_result = alu.alu_in_1 + alu.alu_in_2;
      INS_SUB:            sc_result = diff;
      INS_AND, INS_ANDI:  sc_result = alu.alu_in_1 & alu.alu_in_2;
      INS_OR, INS_ORI:    sc_result = alu.alu_in_1 | alu.alu_in_2;
      INS_XOR, INS_XORI:  sc_result = alu.alu_in_1 ^ alu.alu_in_2;
      INS_BEQ: begin
        sc_result = diff;
        sc_bcond  = (diff == '0);
      end
      INS_BNE: begin
        sc_result = diff;
        sc_bcond  = (diff != '0);
      end
      INS_BLT: begin
        sc_result = diff;
        sc_bcond  = ($signed(alu.alu_in_1) < $signed(alu.alu_in_2));
      end
      INS_BGE: begin
        sc_result = diff;
        sc_bcond  = ($signed(alu.alu_in_1) >= $signed(alu.alu_in_2));
      end
      INS_ECALL:          sc_result = '0;
      INS_SLL, INS_SLLI: begin
        sc_result = alu.alu_in_1;
        is_shift  = 1'b1;
      end
      INS_SRL, INS_SRLI: begin
        sc_result = alu.alu_in_1;
        is_shift  = 1'b1;
        is_right  = 1'b1;
      end
      default:            sc_illegal = 1'b1;
    endcase
  end

  assign acc_shift = right_q ? (acc_q >> 1) : (acc_q << 1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    right_d   = right_q;
    result_d  = result_q;
    bcond_d   = bcond_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (alu.start) begin
          bcond_d   = sc_bcond;
          illegal_d = sc_illegal;
          if (is_shift && (amt != '0)) begin
            acc_d   = alu.alu_in_1;
            cnt_d   = amt;
            right_d = is_right;
            state_d = S_SHIFT;
          end else begin
            result_d = sc_result;
            done_d   = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        acc_d = acc_shift;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d = acc_shift;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      right_q   <= 1'b0;
      result_q  <= '0;
      bcond_q   <= 1'b0;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      right_q   <= right_d;
      result_q  <= result_d;
      bcond_q   <= bcond_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
    end
  end

  assign alu.busy        = (state_q == S_SHIFT);
  assign alu.done        = done_q;
  assign alu.alu_result  = result_q;
  assign alu.alu_bcond   = bcond_q;
  assign alu.alu_illegal = illegal_q;
endmodule

// File: tb/tb_iterative_alu.sv
// tb/tb_iterative_alu.sv - scoreboard bench for iterative_alu against a plain-arithmetic reference
// Driver pushes expected responses with their due cycle; a negedge monitor pops and compares.
module tb_iterative_alu;
  localparam int XLEN = 32;

  localparam logic [4:0] ADD = 5'd0,  ADDI = 5'd1,  SUB = 5'd2,  AND_ = 5'd3, ANDI = 5'd4;
  localparam logic [4:0] OR_ = 5'd5,  ORI  = 5'd6,  XOR_ = 5'd7, XORI = 5'd8, SLL  = 5'd9;
  localparam logic [4:0] SLLI = 5'd10, SRL = 5'd11, SRLI = 5'd12, LW  = 5'd13, SW   = 5'd14;
  localparam logic [4:0] JAL = 5'd15, JALR = 5'd16, BEQ  = 5'd17, BNE = 5'd18, BLT  = 5'd19;
  localparam logic [4:0] BGE = 5'd20, ECALL = 5'd21, ILL = 5'd31;

  typedef struct {
    logic [31:0] res;
    logic        bc;
    logic        ill;
    int          k;
  } ref_t;

  typedef struct {
    logic [31:0] res;
    logic        bc;
    logic        ill;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   busy_lo = 0;
  int   busy_hi = 0;
  exp_t sb[$];

  iterative_alu_if #(.XLEN(XLEN)) bus();

  iterative_alu #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .alu   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
  endtask

  function automatic ref_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    ref_t r;
    r.res = 32'd0;
    r.bc  = 1'b0;
    r.ill = 1'b0;
    r.k   = 0;
    case (op)
      ADD, ADDI, LW, SW, JAL, JALR: r.res = a + b;
      SUB:         r.res = a - b;
      AND_, ANDI:  r.res = a & b;
      OR_, ORI:    r.res = a | b;
      XOR_, XORI:  r.res = a ^ b;
      BEQ: begin r.res = a - b; r.bc = (a == b); end
      BNE: begin r.res = a - b; r.bc = (a != b); end
      BLT: begin r.res = a - b; r.bc = ($signed(a) < $signed(b)); end
      BGE: begin r.res = a - b; r.bc = ($signed(a) >= $signed(b)); end
      ECALL: r.res = 32'd0;
      SLL, SLLI: begin r.k = int'(b % 32); r.res = a << r.k; end
      SRL, SRLI: begin r.k = int'(b % 32); r.res = a >> r.k; end
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  // Operands wiggle randomly while the ALU is busy with start held high: none of it may be taken.
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    ref_t r;
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && guard < 64) begin
      bus.start    = 1'b1;
      bus.alu_op   = 5'($urandom);
      bus.alu_in_1 = $urandom;
      bus.alu_in_2 = $urandom;
      guard++;
      @(negedge clk);
    end
    if (guard >= 64) chk("busy_timeout", 32'(bus.busy), 32'd0);
    bus.start    = 1'b1;
    bus.alu_op   = op;
    bus.alu_in_1 = a;
    bus.alu_in_2 = b;
    r     = model(op, a, b);
    e.res = r.res;
    e.bc  = r.bc;
    e.ill = r.ill;
    e.cyc = cyc + 1 + r.k;
    sb.push_back(e);
    if (r.k > 0) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + 1 + r.k;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic drain();
    int guard = 0;
    idle(1);
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    logic exp_done;
    if (!reset) begin
      exp_busy = (cyc >= busy_lo) && (cyc < busy_hi);
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      exp_done = (sb.size() != 0) && (sb[0].cyc == cyc);
      chk("done", 32'(bus.done), 32'(exp_done));
      if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (bus.done === 1'b1) begin
          chk("alu_result", bus.alu_result, e.res);
          chk("alu_bcond", 32'(bus.alu_bcond), 32'(e.bc));
          chk("alu_illegal", 32'(bus.alu_illegal), 32'(e.ill));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    bus.start    = 1'b0;
    bus.alu_op   = 5'd0;
    bus.alu_in_1 = 32'd0;
    bus.alu_in_2 = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.alu_result, 32'd0);
    chk("rst_bcond", 32'(bus.alu_bcond), 32'd0);
    chk("rst_illegal", 32'(bus.alu_illegal), 32'd0);
    reset = 1'b0;

    send(ADD, 32'h7FFF_FFFF, 32'd1);
    send(SUB, 32'd5, 32'd7);
    send(XORI, 32'hF0F0_F0F0, 32'h0000_00FF);
    send(BLT, 32'hFFFF_FFFF, 32'd1);
    send(BGE, 32'hFFFF_FFFF, 32'd1);
    send(BEQ, 32'd9, 32'd9);
    send(BNE, 32'd9, 32'd9);
    send(SRL, 32'h8000_0000, 32'd31);
    send(SLLI, 32'h1234_5678, 32'd0);
    send(SLL, 32'h0000_0003, 32'h0000_0025);
    send(SLL, 32'h0000_0001, 32'd3);
    for (int i = 0; i < 10; i++) send(ADD, 32'(i), 32'd100);
    send(ILL, 32'hDEAD_BEEF, 32'h1);
    send(ORI, 32'h0000_00F0, 32'h0000_000F);
    send(5'd25, 32'd1, 32'd2);
    send(ECALL, 32'd1, 32'd2);
    send(SRLI, 32'hFFFF_FFFF, 32'd1);
    drain();

    for (int i = 0; i < 150; i++) begin
      op = 5'($urandom);
      a  = $urandom;
      b  = ($urandom_range(3, 0) == 0) ? a : $urandom;
      send(op, a, b);
      if ($urandom_range(4, 0) == 0) idle($urandom_range(3, 1));
    end
    drain();

    send(SLL, 32'd1, 32'd20);
    repeat (4) @(posedge clk);
    #2;
    reset     = 1'b1;
    bus.start = 1'b0;
    sb.delete();
    busy_lo = 0;
    busy_hi = 0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_result", bus.alu_result, 32'd0);
    chk("midrst_bcond", 32'(bus.alu_bcond), 32'd0);
    chk("midrst_illegal", 32'(bus.alu_illegal), 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    idle(3);
    send(ADD, 32'd3, 32'd4);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
